// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshakes of the serial subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, busy
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor step per clock, LSB first,
// behind valid/ready handshakes on operands and result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave s_if
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  // Minuend bits leave from the bottom while difference bits enter at the top,
  // so after WIDTH steps this register holds the result.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_a_next;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_d;
    end else begin : g_wn
      assign w_a_next = {w_d, r_a[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM and datapath registers; every output is driven straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_bin        <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_if.in_valid) begin
            r_a        <= s_if.a;
            r_b        <= s_if.b;
            r_bin      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a   <= w_a_next;
          r_b   <= r_b >> 1'b1;
          r_bin <= w_bout;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_diff       <= w_a_next;
            r_borrow_out <= w_bout;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (s_if.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign s_if.in_ready   = r_in_ready;
  assign s_if.out_valid  = r_out_valid;
  assign s_if.diff       = r_diff;
  assign s_if.borrow_out = r_borrow_out;
  assign s_if.busy       = r_busy;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 builds, directed vectors,
// and a per-cycle arithmetic model of the handshake and result.
module tb_serial_subtractor;

  logic clk    = 1'b0;
  logic rst_n8 = 1'b1;
  logic rst_n1 = 1'b1;
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(8)) s8();
  serial_subtractor_if #(.WIDTH(1)) s1();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n8), .s_if(s8.slave));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n1), .s_if(s1.slave));

  // Model state per build: index 0 is WIDTH=8, index 1 is WIDTH=1.
  bit         pending [2];
  int         age     [2];
  logic [7:0] exp_d   [2];
  logic       exp_b   [2];
  logic [7:0] last_d  [2];
  logic       last_b  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on every falling edge: checks outputs, then predicts the next rising edge.
  task automatic mon(input int id, input int w, input logic rst, input logic iv,
                     input logic ir, input logic [7:0] a, input logic [7:0] b,
                     input logic ov, input logic ordy, input logic [7:0] d,
                     input logic bo, input logic bsy);
    logic [7:0] mask;
    logic       ov_exp;
    mask = (w == 8) ? 8'hFF : 8'h01;
    if (!rst) begin
      chk($sformatf("w%0d_rst_in_ready", w), ir, 1);
      chk($sformatf("w%0d_rst_out_valid", w), ov, 0);
      chk($sformatf("w%0d_rst_busy", w), bsy, 0);
      chk($sformatf("w%0d_rst_diff", w), d, 0);
      chk($sformatf("w%0d_rst_borrow", w), bo, 0);
      pending[id] = 1'b0;
      last_d[id]  = 8'h00;
      last_b[id]  = 1'b0;
    end else begin
      if (pending[id]) age[id]++;
      ov_exp = pending[id] && (age[id] >= w);
      chk($sformatf("w%0d_out_valid", w), ov, ov_exp);
      chk($sformatf("w%0d_in_ready", w), ir, !pending[id]);
      chk($sformatf("w%0d_busy", w), bsy, pending[id]);
      if (ov_exp) begin
        chk($sformatf("w%0d_diff", w), d, exp_d[id]);
        chk($sformatf("w%0d_borrow", w), bo, exp_b[id]);
      end else begin
        chk($sformatf("w%0d_diff_hold", w), d, last_d[id]);
        chk($sformatf("w%0d_borrow_hold", w), bo, last_b[id]);
      end
      if (ov_exp && ordy) begin
        last_d[id]  = exp_d[id];
        last_b[id]  = exp_b[id];
        pending[id] = 1'b0;
      end else if (!pending[id] && iv) begin
        pending[id] = 1'b1;
        age[id]     = -1;
        exp_d[id]   = (a - b) & mask;
        exp_b[id]   = (a < b);
      end
    end
  endtask

  always @(negedge clk)
    mon(0, 8, rst_n8, s8.in_valid, s8.in_ready, s8.a, s8.b, s8.out_valid,
        s8.out_ready, s8.diff, s8.borrow_out, s8.busy);

  always @(negedge clk)
    mon(1, 1, rst_n1, s1.in_valid, s1.in_ready, {7'd0, s1.a}, {7'd0, s1.b},
        s1.out_valid, s1.out_ready, {7'd0, s1.diff}, s1.borrow_out, s1.busy);

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                     input logic eb, input int hold);
    int n;
    n = 0;
    s8.in_valid = 1'b1;
    s8.a = a;
    s8.b = b;
    while (!s8.in_ready && n < 40) begin step(); n++; end
    chk("w8_accept_wait", n < 40, 1);
    step();
    s8.in_valid = 1'b0;
    n = 0;
    while (!s8.out_valid && n < 40) begin step(); n++; end
    chk("w8_latency", n, 8);
    chk("w8_diff_lit", s8.diff, ed);
    chk("w8_borrow_lit", s8.borrow_out, eb);
    for (int k = 0; k < hold; k++) begin
      s8.in_valid = 1'b1;
      s8.a = 8'h11;
      s8.b = 8'h01;
      step();
      chk("w8_hold_out_valid", s8.out_valid, 1);
      chk("w8_hold_in_ready", s8.in_ready, 0);
      chk("w8_hold_diff", s8.diff, ed);
    end
    s8.in_valid  = 1'b0;
    s8.out_ready = 1'b1;
    step();
    chk("w8_out_valid_drop", s8.out_valid, 0);
    chk("w8_in_ready_back", s8.in_ready, 1);
  endtask

  task automatic op1(input logic a, input logic b, input logic ed, input logic eb);
    int n;
    n = 0;
    s1.in_valid = 1'b1;
    s1.a = a;
    s1.b = b;
    while (!s1.in_ready && n < 40) begin step(); n++; end
    chk("w1_accept_wait", n < 40, 1);
    step();
    s1.in_valid = 1'b0;
    n = 0;
    while (!s1.out_valid && n < 40) begin step(); n++; end
    chk("w1_latency", n, 1);
    chk("w1_diff_lit", s1.diff, ed);
    chk("w1_borrow_lit", s1.borrow_out, eb);
    step();
    chk("w1_out_valid_drop", s1.out_valid, 0);
  endtask

  logic [7:0] bb_a [4] = '{8'h12, 8'h99, 8'h01, 8'hC8};
  logic [7:0] bb_b [4] = '{8'h34, 8'h11, 8'h02, 8'h64};
  logic [7:0] bb_d [4] = '{8'hDE, 8'h88, 8'hFF, 8'h64};
  logic [3:0] bb_w     = 4'b0101;
  logic [3:0] w1_d     = 4'b0110;
  logic [3:0] w1_bo    = 4'b0010;
  int         acc  [4];

  initial begin
    int n;
    s8.in_valid = 1'b0; s8.a = 8'h00; s8.b = 8'h00; s8.out_ready = 1'b1;
    s1.in_valid = 1'b0; s1.a = 1'b0;  s1.b = 1'b0;  s1.out_ready = 1'b1;
    #2;
    rst_n8 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) step();
    rst_n8 = 1'b1;
    rst_n1 = 1'b1;
    step();

    op8(8'h5A, 8'h3C, 8'h1E, 1'b0, 0);
    op8(8'h3C, 8'h5A, 8'hE2, 1'b1, 0);
    op8(8'h00, 8'h01, 8'hFF, 1'b1, 0);
    op8(8'hFF, 8'hFF, 8'h00, 1'b0, 0);

    s8.out_ready = 1'b0;
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 5);

    // Abort an operation after four bits; reset must act without a clock edge.
    s8.in_valid = 1'b1;
    s8.a = 8'h5A;
    s8.b = 8'h3C;
    step();
    s8.in_valid = 1'b0;
    repeat (4) step();
    rst_n8 = 1'b0;
    #1;
    chk("w8_async_in_ready", s8.in_ready, 1);
    chk("w8_async_out_valid", s8.out_valid, 0);
    chk("w8_async_busy", s8.busy, 0);
    chk("w8_async_diff", s8.diff, 0);
    chk("w8_async_borrow", s8.borrow_out, 0);
    repeat (2) step();
    rst_n8 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("w8_no_out_valid_after_abort", s8.out_valid, 0);
    end
    op8(8'h10, 8'h01, 8'h0F, 1'b0, 0);

    // Back-to-back operands with in_valid held high throughout.
    s8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s8.a = bb_a[i];
      s8.b = bb_b[i];
      s8.in_valid = 1'b1;
      n = 0;
      while (!s8.in_ready && n < 40) begin step(); n++; end
      chk("b2b_accept_wait", n < 40, 1);
      acc[i] = cyc;
      step();
      n = 0;
      while (!s8.out_valid && n < 40) begin step(); n++; end
      chk("b2b_latency", n, 8);
      chk("b2b_diff", s8.diff, bb_d[i]);
      chk("b2b_borrow", s8.borrow_out, bb_w[i]);
      if (i > 0) chk("b2b_period", acc[i] - acc[i-1], 10);
    end
    s8.in_valid = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      op1(ab[1], ab[0], w1_d[i], w1_bo[i]);
    end

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
